// File: rtl/pixel_accum_sequencer_if.sv
// Handshake and adder-operand bundle for the box-filter accumulator sequencer.
// The slave view belongs to the sequencer. The master view belongs to whatever
// drives samples, owns the external adder and consumes results.
interface pixel_accum_sequencer_if #(
  parameter int N     = 32,
  parameter int PIX_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic [N-1:0]     adder_a;
  logic [N-1:0]     adder_b;
  logic [N-1:0]     adder_sum;
  logic             adder_carry;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_sat;
  logic             out_zero;

  modport slave (
    input  clear, in_valid, in_pixel, adder_sum, adder_carry, out_ready,
    output in_ready, adder_a, adder_b, out_valid, out_pixel, out_sat, out_zero
  );

  modport master (
    output clear, in_valid, in_pixel, adder_sum, adder_carry, out_ready,
    input  in_ready, adder_a, adder_b, out_valid, out_pixel, out_sat, out_zero
  );
endinterface

// File: rtl/pixel_accum_sequencer.sv
// Box-filter window accumulator. It feeds the running sum and the incoming
// pixel to an external combinational adder. It saturates the sum when the
// adder reports a carry. After KSIZE accepted samples it holds one averaged,
// clamped pixel until the consumer takes it.
module pixel_accum_sequencer #(
  parameter int N     = 32,
  parameter int PIX_W = 8,
  parameter int KSIZE = 16,
  parameter int SHIFT = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pixel_accum_sequencer_if.slave bus
);

  localparam int CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KSIZE - 1);
  localparam logic [N-1:0]     PIX_MAX  = {{(N-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [N-1:0]     acc_q,       acc_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             sat_q,       sat_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_sat_q,   out_sat_d;
  logic             out_zero_q,  out_zero_d;

  logic [N-1:0] nsum;
  logic         accept;
  logic         last_sample;

  // Average the window sum and clamp it into the pixel range.
  function automatic logic [PIX_W-1:0] clamp_avg(input logic [N-1:0] sum);
    logic [N-1:0] shifted;
    shifted = sum >> SHIFT;
    if (shifted > PIX_MAX) begin
      return {PIX_W{1'b1}};
    end
    return shifted[PIX_W-1:0];
  endfunction

  // Saturate the adder result. Once the sum is all-ones, every further
  // non-zero pixel carries, so the sum stays pinned.
  function automatic logic [N-1:0] sat_sum(input logic [N-1:0] sum, input logic carry);
    return carry ? {N{1'b1}} : sum;
  endfunction

  // The adder is purely combinational, so these ports are wired straight
  // through with no pipeline.
  assign bus.adder_a   = acc_q;
  assign bus.adder_b   = {{(N-PIX_W){1'b0}}, bus.in_pixel};
  assign bus.in_ready  = rst_n && (state_q == ST_ACC) && !bus.clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_zero  = out_zero_q;

  assign nsum        = sat_sum(bus.adder_sum, bus.adder_carry);
  assign accept      = bus.in_valid && bus.in_ready;
  assign last_sample = (count_q == CNT_LAST);

  // Next-state logic: clear wins; otherwise accumulate in ACC, or wait for
  // the consumer in OUT.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_sat_d   = out_sat_q;
    out_zero_d  = out_zero_q;

    if (bus.clear) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      count_d     = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (last_sample) begin
              out_pixel_d = clamp_avg(nsum);
              out_sat_d   = sat_q | bus.adder_carry;
              out_zero_d  = (nsum == '0);
              out_valid_d = 1'b1;
              state_d     = ST_OUT;
              acc_d       = '0;
              count_d     = '0;
              sat_d       = 1'b0;
            end else begin
              acc_d   = nsum;
              sat_d   = sat_q | bus.adder_carry;
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end
        default: begin
          state_d     = ST_ACC;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State register. Reset is asynchronous and clears every piece of state,
  // so no partial result survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_sat_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_sat_q   <= out_sat_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_pixel_accum_sequencer.sv
// Bench for pixel_accum_sequencer. Two instances, N=32 and N=10, receive the
// same stimulus. Each has its own combinational adder. Each is compared every
// cycle against a window-level model: the expected sum is min(true sum, 2^N-1),
// and saturation is flagged when the true sum exceeds 2^N-1.
module tb_pixel_accum_sequencer;

  localparam int PIX_W = 8;
  localparam int KSIZE = 16;
  localparam int SHIFT = 4;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  pixel_accum_sequencer_if #(.N(32), .PIX_W(PIX_W)) if32 ();
  pixel_accum_sequencer_if #(.N(10), .PIX_W(PIX_W)) if10 ();

  pixel_accum_sequencer #(.N(32), .PIX_W(PIX_W), .KSIZE(KSIZE), .SHIFT(SHIFT)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32.slave)
  );

  pixel_accum_sequencer #(.N(10), .PIX_W(PIX_W), .KSIZE(KSIZE), .SHIFT(SHIFT)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if10.slave)
  );

  assign {if32.adder_carry, if32.adder_sum} = {1'b0, if32.adder_a} + {1'b0, if32.adder_b};
  assign {if10.adder_carry, if10.adder_sum} = {1'b0, if10.adder_a} + {1'b0, if10.adder_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state. Index 0 is the N=32 instance; index 1 is N=10.
  longint nmax [2];
  longint tsum [2];
  int     cnt;
  bit     m_out;
  longint e_pix  [2];
  bit     e_sat  [2];
  bit     e_zero [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tsum[0] = 0;
    tsum[1] = 0;
    cnt     = 0;
    m_out   = 0;
    for (int i = 0; i < 2; i++) begin
      e_pix[i]  = 0;
      e_sat[i]  = 0;
      e_zero[i] = 0;
    end
  endtask

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_inst(input int i, input string nm, input logic rdy, input logic [31:0] a,
                            input logic ov, input logic [7:0] px, input logic s, input logic z,
                            input bit exp_rdy);
    chk({nm, "_in_ready"},  64'(rdy), 64'(exp_rdy));
    chk({nm, "_adder_a"},   64'(a),   64'(lmin(tsum[i], nmax[i])));
    chk({nm, "_out_valid"}, 64'(ov),  64'(m_out));
    chk({nm, "_out_pixel"}, 64'(px),  64'(e_pix[i]));
    chk({nm, "_out_sat"},   64'(s),   64'(e_sat[i]));
    chk({nm, "_out_zero"},  64'(z),   64'(e_zero[i]));
  endtask

  // One clock cycle: drive the inputs, check both DUTs at the falling edge,
  // then advance the model across the next rising edge.
  task automatic cycle(input bit v, input logic [7:0] px, input bit ordy, input bit clr);
    bit exp_rdy;
    if32.in_valid = v;    if10.in_valid = v;
    if32.in_pixel = px;   if10.in_pixel = px;
    if32.out_ready = ordy; if10.out_ready = ordy;
    if32.clear = clr;     if10.clear = clr;
    @(negedge clk);
    exp_rdy = !m_out && !clr;
    check_inst(0, "n32", if32.in_ready, if32.adder_a, if32.out_valid, if32.out_pixel,
               if32.out_sat, if32.out_zero, exp_rdy);
    check_inst(1, "n10", if10.in_ready, {22'd0, if10.adder_a}, if10.out_valid, if10.out_pixel,
               if10.out_sat, if10.out_zero, exp_rdy);
    if (clr) begin
      tsum[0] = 0;
      tsum[1] = 0;
      cnt     = 0;
      m_out   = 0;
    end else if (m_out) begin
      if (ordy) m_out = 0;
    end else if (v) begin
      tsum[0] += px;
      tsum[1] += px;
      cnt++;
      if (cnt == KSIZE) begin
        for (int i = 0; i < 2; i++) begin
          longint ns;
          ns        = lmin(tsum[i], nmax[i]);
          e_pix[i]  = lmin(ns >> SHIFT, 255);
          e_sat[i]  = (tsum[i] > nmax[i]);
          e_zero[i] = (ns == 0);
          tsum[i]   = 0;
        end
        cnt   = 0;
        m_out = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [7:0] px);
    for (int k = 0; k < n; k++) cycle(1'b1, px, 1'b0, 1'b0);
  endtask

  // Assert reset between clock edges and check that the outputs drop at once.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_n32_in_ready",  64'(if32.in_ready),  64'd0);
    chk("rst_n32_adder_a",   64'(if32.adder_a),   64'd0);
    chk("rst_n32_out_valid", 64'(if32.out_valid), 64'd0);
    chk("rst_n32_out_pixel", 64'(if32.out_pixel), 64'd0);
    chk("rst_n32_out_sat",   64'(if32.out_sat),   64'd0);
    chk("rst_n32_out_zero",  64'(if32.out_zero),  64'd0);
    chk("rst_n10_out_valid", 64'(if10.out_valid), 64'd0);
    chk("rst_n10_out_pixel", 64'(if10.out_pixel), 64'd0);
    chk("rst_n10_out_sat",   64'(if10.out_sat),   64'd0);
    chk("rst_n10_adder_a",   64'(if10.adder_a),   64'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    nmax[0] = 64'h0000_0000_FFFF_FFFF;
    nmax[1] = 1023;
    model_reset();
    rst_n = 1'b0;
    if32.in_valid = 0; if32.in_pixel = 0; if32.out_ready = 0; if32.clear = 0;
    if10.in_valid = 0; if10.in_pixel = 0; if10.out_ready = 0; if10.clear = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    cycle(1'b0, 8'd0, 1'b0, 1'b0);

    // 16 samples of 10, then the result is held for 5 cycles with in_valid high.
    feed(16, 8'd10);
    chk("tp_pix10", 64'(if32.out_pixel), 64'd10);
    chk("tp_vld10", 64'(if32.out_valid), 64'd1);
    repeat (5) cycle(1'b1, 8'd77, 1'b0, 1'b0);
    cycle(1'b1, 8'd77, 1'b1, 1'b0);
    chk("tp_rdy_after", 64'(if32.in_ready), 64'd1);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    // 16 samples of 255: N=32 averages to 255; N=10 pins at 1023 and gives 63.
    feed(16, 8'd255);
    chk("tp_sat_pix", 64'(if10.out_pixel), 64'd63);
    chk("tp_sat_flag", 64'(if10.out_sat), 64'd1);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // A window of zeros.
    feed(16, 8'd0);
    chk("tp_zero", 64'(if32.out_zero), 64'd1);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // Abort a partial window of 200s; the sample presented with clear is dropped.
    feed(7, 8'd200);
    cycle(1'b1, 8'd200, 1'b0, 1'b1);
    feed(16, 8'd16);
    chk("tp_clear_pix", 64'(if32.out_pixel), 64'd16);
    chk("tp_clear_sat", 64'(if10.out_sat), 64'd0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // Reset mid-window, then reset while a result is pending.
    feed(9, 8'd100);
    async_reset();
    feed(16, 8'd20);
    chk("tp_rst_pix", 64'(if32.out_pixel), 64'd20);
    async_reset();
    feed(16, 8'd40);
    chk("tp_rst2_pix", 64'(if32.out_pixel), 64'd40);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);

    // Randomised traffic with gaps, back-pressure and occasional clears.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] px;
      int mode;
      mode = $urandom_range(0, 3);
      if (mode == 0)      px = 8'd255;
      else if (mode == 1) px = 8'($urandom_range(0, 15));
      else                px = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 3) != 0), px, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
